da_bitslice_gen: RTL and testbench

Bit-slice address generator for the distributed-arithmetic (DA) convolution datapath. It accepts one vector of K signed activations and serializes it LSB-first into offset-binary slices. Each slice drives the LUT stage's `A0`, `addr_array`, `gen_done` and `t` inputs, one slice per clock. It sits directly upstream of the LUT/shift-accumulate pair and is the producer side of that address interface.

---
 rtl/da_bitslice_gen.sv | 162 ++++++++++++++++
 tb/tb_da_bitslice_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/da_bitslice_gen.sv
// Bit-slice address generator for the DA convolution datapath: serializes a K-element
// activation vector LSB-first into offset-binary slices. Optional macro DA_GEN_PINGPONG_EN.
module da_bitslice_gen #(
    parameter int DATA_WIDTH_A = 16,
    parameter int K            = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [K*DATA_WIDTH_A-1:0] A_in,
    input  logic                      stall,
    output logic                      A0,
    output logic [K-2:0]              addr_array,
    output logic                      gen_done,
    output logic [7:0]                t,
    output logic                      out_last,
    output logic                      busy
);

    localparam int         TW   = (DATA_WIDTH_A > 1) ? $clog2(DATA_WIDTH_A) : 1;
    localparam logic [7:0] LAST = 8'(DATA_WIDTH_A - 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              t_q, t_d;
    logic [DATA_WIDTH_A-1:0] aReg_q [K];
    logic [DATA_WIDTH_A-1:0] aReg_d [K];
    logic [DATA_WIDTH_A-1:0] inVec  [K];
    logic                    a0_q, a0_d;
    logic [K-2:0]            addr_q, addr_d;
    logic                    accept;

`ifdef DA_GEN_PINGPONG_EN
    logic                    bufFull_q, bufFull_d;
    logic [DATA_WIDTH_A-1:0] aBuf_q [K];
    logic [DATA_WIDTH_A-1:0] aBuf_d [K];

    assign in_ready = rst && !bufFull_q && !stall;
    assign busy     = (state_q == SHIFT) || bufFull_q;
`else
    assign in_ready = rst && (state_q == IDLE) && !stall;
    assign busy     = (state_q == SHIFT);
`endif

    assign accept     = in_valid && in_ready;
    assign gen_done   = (state_q == SHIFT);
    assign t          = t_q;
    assign out_last   = gen_done && (t_q == LAST);
    assign A0         = a0_q;
    assign addr_array = addr_q;

    always_comb begin
        for (int i = 0; i < K; i++) begin
            inVec[i] = A_in[i*DATA_WIDTH_A +: DATA_WIDTH_A];
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        aReg_d  = aReg_q;
`ifdef DA_GEN_PINGPONG_EN
        bufFull_d = bufFull_q;
        aBuf_d    = aBuf_q;
`endif
        if (!stall) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        aReg_d  = inVec;
                        state_d = SHIFT;
                        t_d     = '0;
                    end
                end
                SHIFT: begin
                    if (t_q != LAST) begin
                        t_d = t_q + 8'd1;
`ifdef DA_GEN_PINGPONG_EN
                        if (accept) begin
                            aBuf_d    = inVec;
                            bufFull_d = 1'b1;
                        end
`endif
                    end else begin
                        t_d = '0;
`ifdef DA_GEN_PINGPONG_EN
                        // Sign slice: hand over the buffered vector (or a fresh one) with no gap
                        if (bufFull_q) begin
                            aReg_d    = aBuf_q;
                            bufFull_d = accept;
                            if (accept) begin
                                aBuf_d = inVec;
                            end
                        end else if (accept) begin
                            aReg_d = inVec;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                    t_d     = '0;
                end
            endcase
        end
    end

    // Slice outputs are registered from next-state values so they line up with t and gen_done
    always_comb begin
        logic [TW-1:0] sliceIdx;
        logic          b0;
        a0_d     = 1'b0;
        addr_d   = '0;
        sliceIdx = t_d[TW-1:0];
        b0       = aReg_d[0][sliceIdx];
        if (state_d == SHIFT) begin
            a0_d = (t_d == LAST) ? ~b0 : b0;
            for (int i = 1; i < K; i++) begin
                addr_d[i-1] = ~(aReg_d[i][sliceIdx] ^ b0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            a0_q    <= 1'b0;
            addr_q  <= '0;
            for (int i = 0; i < K; i++) begin
                aReg_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            a0_q    <= a0_d;
            addr_q  <= addr_d;
            aReg_q  <= aReg_d;
        end
    end

`ifdef DA_GEN_PINGPONG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bufFull_q <= 1'b0;
            for (int i = 0; i < K; i++) begin
                aBuf_q[i] <= '0;
            end
        end else begin
            bufFull_q <= bufFull_d;
            aBuf_q    <= aBuf_d;
        end
    end
`endif

endmodule

// File: tb/tb_da_bitslice_gen.sv
// Testbench for da_bitslice_gen: directed test-plan steps plus random traffic
// checked against a queue-based reference model of the slice stream.
module tb_da_bitslice_gen;

    localparam int DW = 4;
    localparam int K  = 9;

    typedef logic [K*DW-1:0] vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         stall = 1'b0;
    vec_t         A_in = '0;
    logic         in_ready, A0, gen_done, out_last, busy;
    logic [K-2:0] addr_array;
    logic [7:0]   t;

    int   errors = 0;
    int   checks = 0;
    int   gdCount = 0;
    bit   lastAcc = 1'b0;

    vec_t pending[$];
    vec_t curVec = '0;
    bit   active = 1'b0;
    int   j = 0;

    da_bitslice_gen #(.DATA_WIDTH_A(DW), .K(K)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A_in(A_in),
        .stall(stall), .A0(A0), .addr_array(addr_array), .gen_done(gen_done), .t(t),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic [DW-1:0] e0, input logic [DW-1:0] eo);
        vec_t v;
        v[DW-1:0] = e0;
        for (int i = 1; i < K; i++) v[i*DW +: DW] = eo;
        return v;
    endfunction

    function automatic logic expReady(input logic s);
`ifdef DA_GEN_PINGPONG_EN
        return rst && (pending.size() == 0) && !s;
`else
        return rst && !active && !s;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected slice: offset-binary LSB-first; sign slice inverts the reference bit only
    task automatic checkOutput();
        logic         b0;
        logic [K-2:0] ea;
        logic         ea0;
        ea  = '0;
        ea0 = 1'b0;
        if (active) begin
            b0 = curVec[j];
            for (int i = 1; i < K; i++) ea[i-1] = (curVec[i*DW + j] == b0);
            ea0 = (j == DW-1) ? ~b0 : b0;
        end
        if (gen_done === 1'b1) gdCount++;
        check("gen_done", 32'(gen_done), 32'(active));
        check("t", 32'(t), active ? 32'(j) : 32'd0);
        check("A0", 32'(A0), 32'(ea0));
        check("addr_array", 32'(addr_array), 32'(ea));
        check("out_last", 32'(out_last), 32'(active && (j == DW-1)));
        check("busy", 32'(busy), 32'(active || (pending.size() > 0)));
        check("in_ready", 32'(in_ready), 32'(expReady(stall)));
    endtask

    task automatic driveCheck(input logic v, input vec_t vec, input logic s);
        @(negedge clk);
        in_valid = v;
        A_in     = vec;
        stall    = s;
        #1;
        checkOutput();
    endtask

    task automatic advance();
        logic acc;
        acc = in_valid && expReady(stall);
        @(posedge clk);
        lastAcc = acc;
        if (!stall) begin
            if (acc) pending.push_back(A_in);
            if (active && (j < DW-1)) begin
                j++;
            end else if (pending.size() > 0) begin
                curVec = pending.pop_front();
                j      = 0;
                active = 1'b1;
            end else begin
                active = 1'b0;
                j      = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input vec_t vec, input logic s);
        driveCheck(v, vec, s);
        advance();
    endtask

    task automatic planCheck(input string tag, input logic [7:0] ea, input logic ea0, input logic el);
        check({tag, " addr"}, 32'(addr_array), 32'(ea));
        check({tag, " A0"}, 32'(A0), 32'(ea0));
        check({tag, " out_last"}, 32'(out_last), 32'(el));
    endtask

    task automatic modelReset();
        pending.delete();
        active = 1'b0;
        j      = 0;
    endtask

    initial begin
        vec_t vB, vS, v1, v2;
        vec_t q[$];
        vB = mkVec(4'b0101, 4'b0011);
        vS = mkVec(4'b1000, 4'b0111);

        #1 rst = 1'b0;
        #2;
        check("reset gen_done", 32'(gen_done), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset addr", 32'(addr_array), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release in_ready", 32'(in_ready), 32'd1);

        // Basic slicing
        applyStimulus(1'b1, vB, 1'b0);
        driveCheck(1'b0, vB, 1'b0); planCheck("basic t0", 8'hFF, 1'b1, 1'b0); advance();
        driveCheck(1'b0, vB, 1'b0); planCheck("basic t1", 8'h00, 1'b0, 1'b0); advance();
        driveCheck(1'b0, vB, 1'b0); planCheck("basic t2", 8'h00, 1'b1, 1'b0); advance();
        driveCheck(1'b0, vB, 1'b0); planCheck("basic t3", 8'hFF, 1'b1, 1'b1); advance();
        applyStimulus(1'b0, vB, 1'b0);

        // Stall for two cycles at t=1
        gdCount = 0;
        applyStimulus(1'b1, vB, 1'b0);
        applyStimulus(1'b0, vB, 1'b0);
        applyStimulus(1'b1, vB, 1'b1);
        applyStimulus(1'b1, vB, 1'b1);
        for (int c = 0; c < 6; c++) applyStimulus(1'b0, vB, 1'b0);
        check("stall gen_done cycles", 32'(gdCount), 32'd6);

        // Back-to-back with in_valid held high
        v1 = vec_t'({$urandom(), $urandom()});
        v2 = vec_t'({$urandom(), $urandom()});
        q.push_back(v1);
        q.push_back(v2);
        for (int c = 0; c < 14; c++) begin
            applyStimulus(q.size() > 0, (q.size() > 0) ? q[0] : '0, 1'b0);
            if (lastAcc && q.size() > 0) void'(q.pop_front());
        end

        // Sign extremes
        applyStimulus(1'b1, vS, 1'b0);
        driveCheck(1'b0, vS, 1'b0); planCheck("sign t0", 8'h00, 1'b0, 1'b0); advance();
        driveCheck(1'b0, vS, 1'b0); planCheck("sign t1", 8'h00, 1'b0, 1'b0); advance();
        driveCheck(1'b0, vS, 1'b0); planCheck("sign t2", 8'h00, 1'b0, 1'b0); advance();
        driveCheck(1'b0, vS, 1'b0); planCheck("sign t3", 8'h00, 1'b0, 1'b1); advance();
        applyStimulus(1'b0, vS, 1'b0);

        // Reset mid-vector at t=2
        applyStimulus(1'b1, vB, 1'b0);
        applyStimulus(1'b0, vB, 1'b0);
        applyStimulus(1'b0, vB, 1'b0);
        driveCheck(1'b0, vB, 1'b0);
        check("pre-reset t", 32'(t), 32'd2);
        #2 rst = 1'b0;
        #1;
        modelReset();
        check("midreset gen_done", 32'(gen_done), 32'd0);
        check("midreset t", 32'(t), 32'd0);
        check("midreset A0", 32'(A0), 32'd0);
        check("midreset addr", 32'(addr_array), 32'd0);
        check("midreset out_last", 32'(out_last), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post-reset in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, vB, 1'b0);
        driveCheck(1'b0, vB, 1'b0); planCheck("restart t0", 8'hFF, 1'b1, 1'b0);
        check("restart t", 32'(t), 32'd0);
        advance();

        // Random traffic with random stalls
        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 9) < 7, vec_t'({$urandom(), $urandom()}),
                          $urandom_range(0, 9) < 2);
        end
        for (int c = 0; c < 12; c++) applyStimulus(1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
